// File: rtl/param_sequence_detector_pkg.sv
// Shared helpers for the parametrised sequence detector.
package param_sequence_detector_pkg;

  // Ceiling log2; used to size the fill counter so it can hold the value N.
  function automatic int unsigned clog2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_sequence_detector_if.sv
// Symbol stream in, match status out, for the parametrised sequence detector.
interface param_sequence_detector_if #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = 4
);
  logic          en;
  logic [W-1:0]  sym_in;
  logic          overlap;
  logic          clear;
  logic          match;
  logic          armed;
  logic [CW-1:0] match_count;

  modport master (output en, sym_in, overlap, clear,
                  input  match, armed, match_count);
  modport slave  (input  en, sym_in, overlap, clear,
                  output match, armed, match_count);
endinterface

// File: rtl/param_sequence_detector_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clr wins.
module sat_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/param_sequence_detector.sv
// Detects PATTERN in the last N accepted W-bit symbols; counts matches.
module param_sequence_detector
  import param_sequence_detector_pkg::*;
#(
  parameter int unsigned     W       = 3,
  parameter int unsigned     N       = 8,
  parameter logic [N*W-1:0]  PATTERN = 24'h37005D,
  parameter int unsigned     CW      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  param_sequence_detector_if.slave   bus
);
  localparam int unsigned    FW   = clog2_ceil(N + 1);
  localparam logic [FW-1:0]  FULL = FW'(N);

  logic [N*W-1:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]  fill_q, fill_d, fill_inc;
  logic           match_q, match_d;
  logic           armed_q, armed_d;
  logic           hit;

  // Newest symbol enters at the LSB end; oldest symbol falls off the top.
  if (N > 1) begin : g_shift
    assign hist_shift = {hist_q[(N-1)*W-1:0], bus.sym_in};
  end else begin : g_single
    assign hist_shift = bus.sym_in;
  end

  assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + FW'(1);

  // Accept/clear decision, comparison against PATTERN and fill update.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit     = 1'b0;
    if (bus.clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      hit    = (fill_inc == FULL) && (hist_shift == PATTERN);
      // Non-overlapping search restarts the fill so N fresh symbols are needed.
      if (hit && !bus.overlap) fill_d = '0;
    end
    match_d = hit;
    armed_d = (fill_d == FULL);
  end

  // History, fill level and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      armed_q <= armed_d;
    end
  end

  sat_counter #(.CW(CW)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clear),
    .inc     (hit),
    .q       (bus.match_count)
  );

  assign bus.match = match_q;
  assign bus.armed = armed_q;
endmodule

// File: tb/tb_param_sequence_detector.sv
// Scoreboard bench for param_sequence_detector across three parameter sets.
module tb_param_sequence_detector;
  logic clk;
  logic reset_n;

  param_sequence_detector_if #(.W(3), .CW(4)) bus_a ();
  param_sequence_detector_if #(.W(1), .CW(4)) bus_b ();
  param_sequence_detector_if #(.W(3), .CW(2)) bus_c ();

  param_sequence_detector #(.W(3), .N(8), .PATTERN(24'h37005D), .CW(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  param_sequence_detector #(.W(1), .N(4), .PATTERN(4'b1010), .CW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));
  param_sequence_detector #(.W(3), .N(8), .PATTERN(24'h37005D), .CW(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c));

  typedef struct {
    string tag;
    int    sel;
    int    m;
    int    c;
    int    a;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: symbols accepted since the last fill restart, oldest first.
  int   win[$];
  int   cur_pat[$];
  int   cur_n;
  int   cur_max;
  int   cur_sel;
  int   m_count;
  int   pat_def[$] = '{1, 5, 6, 0, 0, 1, 3, 5};
  int   pat_bin[$] = '{1, 0, 1, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_cfg(input int sel);
    cur_sel = sel;
    case (sel)
      1:       begin cur_pat = pat_bin; cur_n = 4; cur_max = 15; end
      2:       begin cur_pat = pat_def; cur_n = 8; cur_max = 3;  end
      default: begin cur_pat = pat_def; cur_n = 8; cur_max = 15; end
    endcase
  endtask

  task automatic model_reset();
    win.delete();
    m_count = 0;
  endtask

  function automatic bit win_hit();
    if (win.size() != cur_n) return 1'b0;
    for (int i = 0; i < cur_n; i++)
      if (win[i] != cur_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic read_out(input int sel, output int m, output int c, output int a);
    case (sel)
      1:       begin m = int'(bus_b.match); c = int'(bus_b.match_count); a = int'(bus_b.armed); end
      2:       begin m = int'(bus_c.match); c = int'(bus_c.match_count); a = int'(bus_c.armed); end
      default: begin m = int'(bus_a.match); c = int'(bus_a.match_count); a = int'(bus_a.armed); end
    endcase
  endtask

  // Drive one cycle on the selected DUT, predict, then compare after the edge.
  task automatic step(input string tag, input bit en, input int sym, input bit ov, input bit clr);
    exp_t e;
    int   am, ac, aa;
    case (cur_sel)
      1:       begin bus_b.en = en; bus_b.sym_in = 1'(sym); bus_b.overlap = ov; bus_b.clear = clr; end
      2:       begin bus_c.en = en; bus_c.sym_in = 3'(sym); bus_c.overlap = ov; bus_c.clear = clr; end
      default: begin bus_a.en = en; bus_a.sym_in = 3'(sym); bus_a.overlap = ov; bus_a.clear = clr; end
    endcase
    e.tag = tag;
    e.sel = cur_sel;
    e.m   = 0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      win.push_back(sym);
      if (win.size() > cur_n) void'(win.pop_front());
      if (win_hit()) begin
        e.m = 1;
        if (m_count < cur_max) m_count++;
        if (!ov) win.delete();
      end
    end
    e.c = m_count;
    e.a = (win.size() == cur_n) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    read_out(e.sel, am, ac, aa);
    check_eq({e.tag, ".match"}, am, e.m);
    check_eq({e.tag, ".count"}, ac, e.c);
    check_eq({e.tag, ".armed"}, aa, e.a);
  endtask

  task automatic send_seq(input string tag, input int seq[$], input bit ov);
    foreach (seq[i]) step($sformatf("%s[%0d]", tag, i), 1'b1, seq[i], ov, 1'b0);
  endtask

  task automatic idle_inputs();
    bus_a.en = 0; bus_a.sym_in = '0; bus_a.overlap = 0; bus_a.clear = 0;
    bus_b.en = 0; bus_b.sym_in = '0; bus_b.overlap = 0; bus_b.clear = 0;
    bus_c.en = 0; bus_c.sym_in = '0; bus_c.overlap = 0; bus_c.clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    int seq[$];
    int m, c, a;
    reset_n = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state of every instance.
    for (int s = 0; s < 3; s++) begin
      read_out(s, m, c, a);
      check_eq($sformatf("rst%0d.match", s), m, 0);
      check_eq($sformatf("rst%0d.count", s), c, 0);
      check_eq($sformatf("rst%0d.armed", s), a, 0);
    end

    // 1: single default pattern, then an idle cycle to see the pulse drop.
    set_cfg(0);
    send_seq("t1", pat_def, 1'b1);
    step("t1.idle", 1'b0, 0, 1'b1, 1'b0);

    // 2: near-miss then full pattern.
    do_reset();
    seq = pat_def;
    seq[7] = 4;
    send_seq("t2.miss", seq, 1'b1);
    send_seq("t2.hit", pat_def, 1'b1);

    // 3: self-overlapping binary pattern, both search modes.
    do_reset();
    set_cfg(1);
    seq = '{1, 0, 1, 0, 1, 0, 1, 0};
    send_seq("t3.ov", seq, 1'b1);
    do_reset();
    send_seq("t3.nov", seq, 1'b0);

    // 4: gaps with en=0 mid-sequence.
    do_reset();
    set_cfg(0);
    for (int i = 0; i < 4; i++) step($sformatf("t4.a[%0d]", i), 1'b1, pat_def[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("t4.gap[%0d]", i), 1'b0, int'($urandom_range(7)), 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) step($sformatf("t4.b[%0d]", i), 1'b1, pat_def[i], 1'b1, 1'b0);

    // 5: saturation at CW=2, then clear beating en drops the symbol.
    do_reset();
    set_cfg(2);
    for (int k = 0; k < 5; k++) send_seq($sformatf("t5.p%0d", k), pat_def, 1'b0);
    step("t5.clr", 1'b1, 1, 1'b0, 1'b1);
    seq = '{5, 6, 0, 0, 1, 3, 5};
    send_seq("t5.tail", seq, 1'b0);

    // 6: asynchronous reset mid-sequence after one earlier match.
    do_reset();
    set_cfg(0);
    send_seq("t6.pre", pat_def, 1'b1);
    seq = '{1, 5, 6, 0, 0};
    send_seq("t6.head", seq, 1'b1);
    bus_a.en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    read_out(0, m, c, a);
    check_eq("t6.async.match", m, 0);
    check_eq("t6.async.count", c, 0);
    check_eq("t6.async.armed", a, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    seq = '{1, 3, 5};
    send_seq("t6.tail", seq, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule
